pmem_arbiter_rr: RTL and testbench
==================================

Name: pmem_arbiter_rr

Overview:
- Shares the single burst-memory path (cacheline adaptor) between the instruction cache and the data cache.
- Grants one cacheline transaction at a time.
- Latches the winner's address and data into registered downstream outputs.
- Routes the response back to the winner only.
- Data cache has priority; a bounded streak counter guarantees instruction-fetch forward progress.

Parameters:
- D_STREAK_MAX, 4: max consecutive dcache grants while an icache request is pending; next grant is then forced to icache.
- PERF_W, 32: width of the grant and wait performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ipmem_address  in  32  icache line address
- ipmem_read  in  1  icache line read request
- ipmem_rdata  out  256  line data to icache
- ipmem_resp  out  1  icache transaction done
- dpmem_address  in  32  dcache line address
- dpmem_wdata  in  256  dcache write-back line
- dpmem_read  in  1  dcache line read request
- dpmem_write  in  1  dcache write-back request
- dpmem_rdata  out  256  line data to dcache
- dpmem_resp  out  1  dcache transaction done
- pmem_address  out  32  registered address to adaptor
- pmem_wdata  out  256  registered write line to adaptor
- pmem_read  out  1  read to adaptor
- pmem_write  out  1  write to adaptor
- pmem_rdata  in  256  line from adaptor
- pmem_resp  in  1  adaptor done
- perf_i_grants  out  PERF_W  icache grants since reset
- perf_d_grants  out  PERF_W  dcache grants since reset
- perf_i_wait  out  PERF_W  cycles ipmem_read was high while not being served

Behaviour:
- Async reset (rst high, any cycle, including mid-transaction):
  - state=IDLE; streak=0; all perf counters=0.
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - ipmem_resp=0, dpmem_resp=0.
  - Any in-flight adaptor transaction is abandoned; the adaptor shares the same reset.
- States:
  - IDLE, SERVE_I, SERVE_D: transaction states.
  - DRAIN: one cycle after each resp. Lets the requester's FSM drop its request; prevents a re-grant of a stale request.
- IDLE arbitration, evaluated each cycle:
  - d_req = dpmem_read | dpmem_write; i_req = ipmem_read.
  - If d_req and (!i_req or streak < D_STREAK_MAX): grant D.
  - Else if i_req: grant I.
  - Else stay IDLE.
- On a D grant:
  - Latch dpmem_address and dpmem_wdata.
  - pmem_write = dpmem_write; pmem_read = dpmem_read & !dpmem_write. Write wins if both are high, which is illegal.
  - streak = i_req ? streak+1 : 0.
  - Go to SERVE_D.
- On an I grant:
  - Latch ipmem_address; pmem_read=1; streak=0.
  - Go to SERVE_I.
- Latency: request sampled in IDLE at cycle N; pmem_read or pmem_write is high from cycle N+1.
- SERVE_x:
  - Downstream outputs held constant; requester inputs are ignored.
  - When pmem_resp=1: the winner's *_resp=1 in the same cycle, combinational. pmem_read and pmem_write drop next cycle. Go to DRAIN.
- Response routing:
  - ipmem_rdata and dpmem_rdata both equal pmem_rdata at all times.
  - Only the winner's resp is asserted; the loser's resp stays 0.
  - No resp outside SERVE states.
- DRAIN: all request outputs low; go to IDLE next cycle. Minimum turnaround between grants is 2 cycles after resp.
- Requester drops its request mid-SERVE: protocol violation. Transaction still completes; resp is pulsed anyway.
- pmem_resp while IDLE or DRAIN: ignored.
- Perf counters:
  - perf_i_grants and perf_d_grants increment on their grant.
  - perf_i_wait increments each cycle with ipmem_read=1 and state != SERVE_I.
  - All counters wrap modulo 2^PERF_W.

Test Plan:
- Single icache read of 0x0000_0060, adaptor resp after 5 cycles:
  - pmem_read=1 with pmem_address=0x60 from N+1.
  - ipmem_resp 1 cycle; dpmem_resp stays 0.
  - perf_i_grants=1.
- Simultaneous ipmem_read (0x100) and dpmem_read (0x200) at cycle N:
  - D served first (address 0x200).
  - After D resp + DRAIN, I served (0x100).
  - perf_i_wait counts every cycle I was unserved.
- Starvation guard, D_STREAK_MAX=4, icache requesting continuously, dcache re-requesting immediately after each DRAIN:
  - Grant order D,D,D,D,I,D…
- Dcache write-back 0x300 with wdata=256'hA5…A5, requester changes address/wdata mid-SERVE:
  - pmem_write=1, pmem_read=0.
  - pmem_address and pmem_wdata stay 0x300 / A5…A5 throughout.
- rst pulsed during SERVE_D, asynchronous, mid-cycle:
  - pmem_read, pmem_write, both resps and all counters = 0 immediately.
  - state IDLE; next request is granted normally.
- Spurious pmem_resp in IDLE, and dpmem_read+dpmem_write both high:
  - No resp emitted for the spurious resp.
  - For the dual request, only pmem_write asserted.

Source files
------------

// File: rtl/pmem_arbiter_rr.sv
// Purpose : shares the single cacheline burst path between icache and dcache, one line transaction at a time.
// Latency : request sampled in IDLE at cycle N -> pmem_read/pmem_write high from N+1; *_resp is same-cycle with pmem_resp.
// Backpres: a requester holds its request until its resp; one DRAIN cycle follows every resp before the next grant.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   ipmem_address/read            icache line read request
//   ipmem_rdata/resp              line data and completion back to icache
//   dpmem_address/wdata/read/write dcache line read or write-back request
//   dpmem_rdata/resp              line data and completion back to dcache
//   pmem_address/wdata/read/write registered request to the cacheline adaptor
//   pmem_rdata/resp               adaptor line data and completion
//   perf_i_grants/d_grants        grants issued per requester since reset
//   perf_i_wait                   cycles the icache request was pending but not being served
//
// Dcache wins ties, but after D_STREAK_MAX back-to-back dcache grants taken
// while the icache was waiting, the next grant is forced to the icache so
// instruction fetch always makes progress.

module pmem_arbiter_rr #(
    parameter int unsigned D_STREAK_MAX = 4,
    parameter int unsigned PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [31:0]       ipmem_address,
    input  logic              ipmem_read,
    output logic [255:0]      ipmem_rdata,
    output logic              ipmem_resp,

    input  logic [31:0]       dpmem_address,
    input  logic [255:0]      dpmem_wdata,
    input  logic              dpmem_read,
    input  logic              dpmem_write,
    output logic [255:0]      dpmem_rdata,
    output logic              dpmem_resp,

    output logic [31:0]       pmem_address,
    output logic [255:0]      pmem_wdata,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic [255:0]      pmem_rdata,
    input  logic              pmem_resp,

    output logic [PERF_W-1:0] perf_i_grants,
    output logic [PERF_W-1:0] perf_d_grants,
    output logic [PERF_W-1:0] perf_i_wait
);

    // The streak never exceeds D_STREAK_MAX: it only increments while it is
    // still below the limit, so this width is always sufficient.
    localparam int unsigned STREAK_W = (D_STREAK_MAX < 1) ? 1 : $clog2(D_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(D_STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] streak;

    logic d_req;
    logic i_req;
    logic grant_d;
    logic grant_i;

    assign d_req = dpmem_read | dpmem_write;
    assign i_req = ipmem_read;

    // Dcache priority, unless it has already taken its allowance of grants
    // while the icache sat waiting.
    assign grant_d = (state == IDLE) && d_req && (!i_req || (streak < STREAK_LIMIT));
    assign grant_i = (state == IDLE) && i_req && !grant_d;

    // ------------------------------------------------------------------
    // Transaction FSM with registered downstream request
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            streak       <= '0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        pmem_address <= dpmem_address;
                        pmem_wdata   <= dpmem_wdata;
                        // Read and write together is illegal; the write wins so
                        // a dirty line is never lost.
                        pmem_write   <= dpmem_write;
                        pmem_read    <= dpmem_read & ~dpmem_write;
                        streak       <= i_req ? (streak + STREAK_W'(1)) : '0;
                        state        <= SERVE_D;
                    end else if (grant_i) begin
                        pmem_address <= ipmem_address;
                        pmem_read    <= 1'b1;
                        pmem_write   <= 1'b0;
                        streak       <= '0;
                        state        <= SERVE_I;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Requester inputs are ignored here; the latched request is
                    // held until the adaptor completes.
                    if (pmem_resp) begin
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The requester drops its request during this cycle, so the
                    // stale request is never sampled as a new one.
                    state <= IDLE;
                end
                default: begin
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response routing: data is broadcast, completion goes to the winner only
    // ------------------------------------------------------------------
    assign ipmem_rdata = pmem_rdata;
    assign dpmem_rdata = pmem_rdata;
    assign ipmem_resp  = (state == SERVE_I) & pmem_resp;
    assign dpmem_resp  = (state == SERVE_D) & pmem_resp;

    // ------------------------------------------------------------------
    // Performance counters, free-running and wrapping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_i_grants <= '0;
            perf_d_grants <= '0;
            perf_i_wait   <= '0;
        end else begin
            if (grant_i) begin
                perf_i_grants <= perf_i_grants + PERF_W'(1);
            end
            if (grant_d) begin
                perf_d_grants <= perf_d_grants + PERF_W'(1);
            end
            if (ipmem_read && (state != SERVE_I)) begin
                perf_i_wait <= perf_i_wait + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pmem_arbiter_rr.sv
// Purpose : exercises pmem_arbiter_rr with directed scenarios then a randomized requester/adaptor mix.
// Latency : bench drives on the falling edge and samples there (or 1 time unit later for combinational resp).
// Backpres: requesters hold until their resp and drop during the following cycle, like the real caches.

module tb_pmem_arbiter_rr;

    localparam int DMAX = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  ipmem_address;
    logic         ipmem_read;
    logic [255:0] ipmem_rdata;
    logic         ipmem_resp;
    logic [31:0]  dpmem_address;
    logic [255:0] dpmem_wdata;
    logic         dpmem_read;
    logic         dpmem_write;
    logic [255:0] dpmem_rdata;
    logic         dpmem_resp;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  perf_i_grants;
    logic [31:0]  perf_d_grants;
    logic [31:0]  perf_i_wait;

    always #5 clk = ~clk;

    pmem_arbiter_rr #(
        .D_STREAK_MAX (DMAX),
        .PERF_W       (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ipmem_address (ipmem_address),
        .ipmem_read    (ipmem_read),
        .ipmem_rdata   (ipmem_rdata),
        .ipmem_resp    (ipmem_resp),
        .dpmem_address (dpmem_address),
        .dpmem_wdata   (dpmem_wdata),
        .dpmem_read    (dpmem_read),
        .dpmem_write   (dpmem_write),
        .dpmem_rdata   (dpmem_rdata),
        .dpmem_resp    (dpmem_resp),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .perf_i_grants (perf_i_grants),
        .perf_d_grants (perf_d_grants),
        .perf_i_wait   (perf_i_wait)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pmem_read || pmem_write) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Reference model state for the randomized phase: a transaction-level view
    // (who owns the path, what was latched, when the path frees up again).
    int           k;
    int           idle_from;
    int           streak_m;
    int           lat;
    int           i_gap;
    int           d_gap;
    bit           busy;
    bit           own_i;
    bit           pre_busy;
    bit           pre_own_i;
    bit           i_got;
    bit           d_got;
    bit           ok;
    bit           dq;
    bit           dut_d;
    logic [31:0]  t_addr;
    logic [255:0] t_wdata;
    bit           t_write;
    logic [31:0]  exp_ig;
    logic [31:0]  exp_dg;
    logic [31:0]  exp_iw;
    logic [255:0] r_line;
    logic [255:0] a5_line;
    bit           order_d [6];

    initial begin
        rst           = 1'b1;
        ipmem_address = '0;
        ipmem_read    = 1'b0;
        dpmem_address = '0;
        dpmem_wdata   = '0;
        dpmem_read    = 1'b0;
        dpmem_write   = 1'b0;
        pmem_rdata    = '0;
        pmem_resp     = 1'b0;
        a5_line       = {32{8'hA5}};
        order_d       = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // ---------------- reset state ----------------
        #3;
        chk("rst_read",   pmem_read, 0);
        chk("rst_write",  pmem_write, 0);
        chk("rst_addr",   pmem_address, 0);
        chk("rst_wdata",  pmem_wdata, 0);
        chk("rst_iresp",  ipmem_resp, 0);
        chk("rst_dresp",  dpmem_resp, 0);
        chk("rst_igr",    perf_i_grants, 0);
        chk("rst_dgr",    perf_d_grants, 0);
        chk("rst_iwait",  perf_i_wait, 0);
        tick();
        rst = 1'b0;

        // ---------------- single icache read ----------------
        ipmem_address = 32'h0000_0060;
        ipmem_read    = 1'b1;
        tick();
        chk("t1_read",  pmem_read, 1);
        chk("t1_write", pmem_write, 0);
        chk("t1_addr",  pmem_address, 32'h60);
        repeat (4) tick();
        chk("t1_hold",  pmem_read, 1);
        r_line     = rnd256();
        pmem_rdata = r_line;
        pmem_resp  = 1'b1;
        #1;
        chk("t1_iresp", ipmem_resp, 1);
        chk("t1_dresp", dpmem_resp, 0);
        chk("t1_rdata", ipmem_rdata, r_line);
        tick();
        pmem_resp  = 1'b0;
        ipmem_read = 1'b0;
        chk("t1_drop",  pmem_read, 0);
        chk("t1_iresp_off", ipmem_resp, 0);
        tick();
        chk("t1_igr",   perf_i_grants, 1);
        chk("t1_dgr",   perf_d_grants, 0);
        chk("t1_iwait", perf_i_wait, 1);

        // ---------------- simultaneous I and D ----------------
        ipmem_address = 32'h100;
        ipmem_read    = 1'b1;
        dpmem_address = 32'h200;
        dpmem_read    = 1'b1;
        tick();
        chk("t2_d_first", pmem_address, 32'h200);
        chk("t2_read",    pmem_read, 1);
        tick();
        tick();
        pmem_resp = 1'b1;
        #1;
        chk("t2_dresp", dpmem_resp, 1);
        chk("t2_iresp", ipmem_resp, 0);
        tick();
        pmem_resp  = 1'b0;
        dpmem_read = 1'b0;
        chk("t2_drain", pmem_read, 0);
        tick();
        chk("t2_turn",  pmem_read, 0);
        tick();
        chk("t2_i_next", pmem_address, 32'h100);
        chk("t2_i_read", pmem_read, 1);
        chk("t2_iwait",  perf_i_wait, 7);
        chk("t2_igr",    perf_i_grants, 2);
        chk("t2_dgr",    perf_d_grants, 1);
        pmem_resp = 1'b1;
        #1;
        chk("t2_iresp2", ipmem_resp, 1);
        tick();
        pmem_resp  = 1'b0;
        ipmem_read = 1'b0;
        tick();

        // ---------------- starvation guard ----------------
        ipmem_address = 32'h500;
        dpmem_address = 32'h400;
        ipmem_read    = 1'b1;
        dpmem_read    = 1'b1;
        for (int g = 0; g < 6; g++) begin
            tick();
            wait_grant(ok);
            chk("starve_timeout", ok, 1);
            chk($sformatf("starve_order%0d", g), pmem_address, order_d[g] ? 32'h400 : 32'h500);
            dut_d     = (pmem_address == 32'h400);
            pmem_resp = 1'b1;
            tick();
            pmem_resp = 1'b0;
            if (dut_d) dpmem_read = 1'b0;
            else       ipmem_read = 1'b0;
            tick();
            if (g < 5) begin
                ipmem_read = 1'b1;
                dpmem_read = 1'b1;
            end else begin
                ipmem_read = 1'b0;
                dpmem_read = 1'b0;
            end
        end
        tick();

        // ---------------- dcache write-back, inputs change mid-serve ----------------
        dpmem_address = 32'h300;
        dpmem_wdata   = a5_line;
        dpmem_write   = 1'b1;
        tick();
        chk("wb_write", pmem_write, 1);
        chk("wb_read",  pmem_read, 0);
        chk("wb_addr",  pmem_address, 32'h300);
        chk("wb_wdata", pmem_wdata, a5_line);
        dpmem_address = 32'hDEAD_BEE0;
        dpmem_wdata   = '0;
        dpmem_write   = 1'b0;
        tick();
        tick();
        chk("wb_addr_hold",  pmem_address, 32'h300);
        chk("wb_wdata_hold", pmem_wdata, a5_line);
        chk("wb_write_hold", pmem_write, 1);
        pmem_resp = 1'b1;
        #1;
        chk("wb_dresp", dpmem_resp, 1);
        tick();
        pmem_resp = 1'b0;
        tick();

        // ---------------- spurious resp, then dual read+write ----------------
        pmem_resp = 1'b1;
        #1;
        chk("sp_iresp", ipmem_resp, 0);
        chk("sp_dresp", dpmem_resp, 0);
        tick();
        pmem_resp = 1'b0;
        chk("sp_read",  pmem_read, 0);
        chk("sp_write", pmem_write, 0);
        dpmem_address = 32'h800;
        dpmem_read    = 1'b1;
        dpmem_write   = 1'b1;
        tick();
        chk("dual_write", pmem_write, 1);
        chk("dual_read",  pmem_read, 0);
        pmem_resp = 1'b1;
        tick();
        pmem_resp   = 1'b0;
        dpmem_read  = 1'b0;
        dpmem_write = 1'b0;
        tick();

        // ---------------- asynchronous reset during SERVE_D ----------------
        dpmem_address = 32'h700;
        dpmem_read    = 1'b1;
        tick();
        chk("ar_read_pre", pmem_read, 1);
        pmem_resp = 1'b1;
        #1;
        chk("ar_dresp_pre", dpmem_resp, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_read",  pmem_read, 0);
        chk("ar_write", pmem_write, 0);
        chk("ar_dresp", dpmem_resp, 0);
        chk("ar_iresp", ipmem_resp, 0);
        chk("ar_dgr",   perf_d_grants, 0);
        chk("ar_igr",   perf_i_grants, 0);
        chk("ar_iwait", perf_i_wait, 0);
        tick();
        rst       = 1'b0;
        pmem_resp = 1'b0;
        tick();
        chk("ar_regrant",  pmem_read, 1);
        chk("ar_addr",     pmem_address, 32'h700);
        chk("ar_dgr_post", perf_d_grants, 1);
        pmem_resp = 1'b1;
        tick();
        pmem_resp  = 1'b0;
        dpmem_read = 1'b0;
        tick();

        // ---------------- randomized traffic against the model ----------------
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        k         = 0;
        idle_from = 0;
        streak_m  = 0;
        lat       = 0;
        i_gap     = 0;
        d_gap     = 0;
        busy      = 1'b0;
        own_i     = 1'b0;
        i_got     = 1'b0;
        d_got     = 1'b0;
        t_addr    = '0;
        t_wdata   = '0;
        t_write   = 1'b0;
        exp_ig    = '0;
        exp_dg    = '0;
        exp_iw    = '0;

        for (int c = 0; c < 3000; c++) begin
            tick();
            k++;
            // Outcome of rising edge k, from the inputs the bench held across it.
            pre_busy  = busy;
            pre_own_i = own_i;
            if (ipmem_read && !(pre_busy && pre_own_i)) exp_iw++;
            if (pre_busy) begin
                if (pmem_resp) begin
                    busy      = 1'b0;
                    idle_from = k + 2;   // one DRAIN cycle, then arbitration again
                end
            end else if (k >= idle_from) begin
                dq = dpmem_read | dpmem_write;
                if (dq && (!ipmem_read || streak_m < DMAX)) begin
                    busy     = 1'b1;
                    own_i    = 1'b0;
                    t_addr   = dpmem_address;
                    t_wdata  = dpmem_wdata;
                    t_write  = dpmem_write;
                    streak_m = ipmem_read ? streak_m + 1 : 0;
                    exp_dg++;
                    lat      = $urandom_range(0, 5);
                end else if (ipmem_read) begin
                    busy     = 1'b1;
                    own_i    = 1'b1;
                    t_addr   = ipmem_address;
                    t_write  = 1'b0;
                    streak_m = 0;
                    exp_ig++;
                    lat      = $urandom_range(0, 5);
                end
            end

            chk("rnd_read",  pmem_read,  busy && !t_write);
            chk("rnd_write", pmem_write, busy && t_write);
            if (busy) begin
                chk("rnd_addr", pmem_address, t_addr);
                if (t_write) chk("rnd_wdata", pmem_wdata, t_wdata);
            end
            chk("rnd_igr",   perf_i_grants, exp_ig);
            chk("rnd_dgr",   perf_d_grants, exp_dg);
            chk("rnd_iwait", perf_i_wait,   exp_iw);

            // icache requester
            if (i_got) begin
                ipmem_read = 1'b0;
                i_gap      = $urandom_range(0, 3);
                i_got      = 1'b0;
            end else if (!ipmem_read) begin
                if (i_gap == 0) begin
                    ipmem_read    = 1'b1;
                    ipmem_address = $urandom() & 32'hFFFF_FFE0;
                end else begin
                    i_gap--;
                end
            end

            // dcache requester; scrambles its inputs while being served
            if (d_got) begin
                dpmem_read  = 1'b0;
                dpmem_write = 1'b0;
                d_gap       = $urandom_range(0, 3);
                d_got       = 1'b0;
            end else if (!(dpmem_read || dpmem_write)) begin
                if (d_gap == 0) begin
                    dpmem_address = $urandom() & 32'hFFFF_FFE0;
                    dpmem_wdata   = rnd256();
                    if ($urandom_range(0, 1) == 1) dpmem_write = 1'b1;
                    else                           dpmem_read  = 1'b1;
                end else begin
                    d_gap--;
                end
            end else if (busy && !own_i && $urandom_range(0, 3) == 0) begin
                dpmem_address = $urandom();
                dpmem_wdata   = rnd256();
            end

            // adaptor, with occasional spurious completions while idle
            pmem_resp  = 1'b0;
            pmem_rdata = rnd256();
            if (busy) begin
                if (lat == 0) pmem_resp = 1'b1;
                else          lat--;
            end else if ($urandom_range(0, 15) == 0) begin
                pmem_resp = 1'b1;
            end
            #1;
            chk("rnd_iresp", ipmem_resp, busy && own_i && pmem_resp);
            chk("rnd_dresp", dpmem_resp, busy && !own_i && pmem_resp);
            if (pmem_resp) begin
                chk("rnd_irdata", ipmem_rdata, pmem_rdata);
                chk("rnd_drdata", dpmem_rdata, pmem_rdata);
            end
            i_got = busy && own_i && pmem_resp;
            d_got = busy && !own_i && pmem_resp;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
